// File: rtl/uart_rx_if.sv
// Serial-side and core-side signals of the UART receiver.
// The master drives the serial line and baud select. The slave is the receiver.
interface uart_rx_if;
    logic       uart_d_in;
    logic [1:0] freq_control;
    logic [7:0] uart_d_out;
    logic       uart_rx_valid;
    logic       uart_frame_error;
    logic       uart_rx_busy;

    modport master (
        output uart_d_in,
        output freq_control,
        input  uart_d_out,
        input  uart_rx_valid,
        input  uart_frame_error,
        input  uart_rx_busy
    );

    modport slave (
        input  uart_d_in,
        input  freq_control,
        output uart_d_out,
        output uart_rx_valid,
        output uart_frame_error,
        output uart_rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with the freq_control baud table shared with uart_tx, a valid strobe and a framing-error flag.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote at every sample point.
module uart_rx #(
    parameter logic [27:0] clock_freq  = 28'd50000000,
    parameter int          sync_stages = 2
) (
    input  logic     uart_clock,
    input  logic     uart_reset,
    uart_rx_if.slave bus
);

    if (sync_stages < 2 || sync_stages > 3 || clock_freq == 28'd0) begin : g_bad_param
        $error("uart_rx: sync_stages must be 2 or 3 and clock_freq nonzero");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    function automatic logic [12:0] pulse_for(input logic [1:0] fc);
        case (fc)
            2'b00:   pulse_for = 13'd5208;
            2'b01:   pulse_for = 13'd434;
            2'b10:   pulse_for = 13'd50;
            default: pulse_for = 13'd12;
        endcase
    endfunction

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [sync_stages-1:0]   r_sync;
    logic                     r_rx_prev;
    logic [12:0]              r_pulse_dur;
    logic [23:0]              r_clk_count;
    logic [2:0]               r_bit_idx;
    logic [7:0]               r_shift;
    logic [7:0]               r_d_out;
    logic                     r_valid;
    logic                     r_frame_err;

    logic                     w_rx_s;
    logic                     w_bit;
    logic [12:0]              w_target;
    logic                     w_at_target;
    logic                     w_shift_en;
    logic                     w_valid_nxt;
    logic                     w_err_nxt;
    logic                     w_latch_fc;

    assign w_rx_s      = r_sync[sync_stages-1];
    assign w_target    = (r_state == S_START) ? {1'b0, r_pulse_dur[12:1]} : r_pulse_dur;
    assign w_at_target = (r_clk_count == {11'd0, w_target});

`ifdef UART_RX_MAJORITY_EN
    // The two previous rx_s values are the target-2 and target-1 samples of the same bit.
    logic r_rx_prev2;
    assign w_bit = (r_rx_prev2 & r_rx_prev) | (r_rx_prev2 & w_rx_s) | (r_rx_prev & w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_latch_fc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rx_prev && !w_rx_s) begin
                    w_state_nxt = S_START;
                    w_latch_fc  = 1'b1;
                end
            end
            S_START: begin
                if (w_at_target) begin
                    w_state_nxt = w_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_at_target) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_at_target) begin
                    if (w_bit) begin
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge uart_clock) begin
        if (!uart_reset) begin
            r_state     <= S_IDLE;
            r_sync      <= '1;
            r_rx_prev   <= 1'b1;
            r_pulse_dur <= 13'd0;
            r_clk_count <= 24'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'd0;
            r_d_out     <= 8'd0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sync      <= {r_sync[sync_stages-2:0], bus.uart_d_in};
            r_rx_prev   <= w_rx_s;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_err_nxt;

            if (w_latch_fc) begin
                r_pulse_dur <= pulse_for(bus.freq_control);
            end

            // The counter only runs in the timed states and restarts at each sample point.
            if (w_state_nxt != r_state || w_at_target || r_state == S_IDLE || r_state == S_BREAK) begin
                r_clk_count <= 24'd0;
            end else begin
                r_clk_count <= r_clk_count + 24'd1;
            end

            if (r_state == S_START) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_shift_en) begin
                r_shift <= {w_bit, r_shift[7:1]};
            end

            if (w_valid_nxt) begin
                r_d_out <= r_shift;
            end
        end
    end

`ifdef UART_RX_MAJORITY_EN
    always_ff @(posedge uart_clock) begin
        if (!uart_reset) begin
            r_rx_prev2 <= 1'b1;
        end else begin
            r_rx_prev2 <= r_rx_prev;
        end
    end
`endif

    assign bus.uart_d_out       = r_d_out;
    assign bus.uart_rx_valid    = r_valid;
    assign bus.uart_frame_error = r_frame_err;
    assign bus.uart_rx_busy     = (r_state != S_IDLE);

endmodule
